// File: rtl/rv32ima_pkg.sv
// Shared types for the round-robin memory arbiter: RAM status encoding,
// arbiter FSM states and a width helper used to size pointers and counters.
package rv32ima_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ram_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr,
// wrapping to the lowest requester below ptr when none is found.
module rr_picker
  import rv32ima_pkg::*;
#(
  parameter int NCH = 2,
  parameter int PW  = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [PW-1:0]  index
);

  logic found_s;

  // Upper pass from ptr, then a wrap-around pass from channel 0.
  always_comb begin
    grant   = '0;
    index   = '0;
    found_s = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      if (!found_s && req[j] && (PW'(j) >= ptr)) begin
        grant[j] = 1'b1;
        index    = PW'(j);
        found_s  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (!found_s && req[j]) begin
        grant[j] = 1'b1;
        index    = PW'(j);
        found_s  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one RAM port among NCH requesters; IDLE grants
// and latches a request, ISSUE drives the RAM, RESP pulses ready or err.
module mem_arbiter_rr
  import rv32ima_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req_ren,
  input  logic [NCH-1:0]           req_wen,
  input  logic [NCH-1:0][AW-1:0]   req_addr,
  input  logic [NCH-1:0][DW-1:0]   req_wdata,
  input  logic [NCH-1:0][DW/8-1:0] req_strb,
  output logic [NCH-1:0]           req_ready,
  output logic [NCH-1:0]           req_err,
  output logic [DW-1:0]            req_rdata,
  output logic                     ram_ren,
  output logic                     ram_wen,
  output logic [AW-1:0]            ram_addr,
  output logic [DW-1:0]            ram_store,
  output logic [DW/8-1:0]          ram_strb,
  input  logic [DW-1:0]            ram_load,
  input  ram_state_t               ram_state
);

  localparam int PW = clog2_min1(NCH);
  localparam int CW = clog2_min1(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  arb_state_t     state_r;
  logic [PW-1:0]  ptr_r;
  logic [PW-1:0]  gidx_r;
  logic [NCH-1:0] grant_r;
  logic [CW-1:0]  cnt_r;
  logic [NCH-1:0] req_any_s;
  logic [NCH-1:0] pick_grant_s;
  logic [PW-1:0]  pick_idx_s;
  logic           conflict_s;

  assign req_any_s  = req_ren | req_wen;
  assign conflict_s = req_ren[pick_idx_s] & req_wen[pick_idx_s];

  rr_picker #(.NCH(NCH), .PW(PW)) u_picker (
    .req   (req_any_s),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .index (pick_idx_s)
  );

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    return (g == PW'(NCH - 1)) ? '0 : g + PW'(1);
  endfunction

  // Arbiter FSM with all RAM-side and requester-side outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      gidx_r    <= '0;
      grant_r   <= '0;
      cnt_r     <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
      ram_strb  <= '0;
      req_ready <= '0;
      req_err   <= '0;
      req_rdata <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_any_s) begin
            grant_r <= pick_grant_s;
            gidx_r  <= pick_idx_s;
            // A simultaneous read and write is rejected without touching the RAM.
            if (conflict_s) begin
              req_err <= pick_grant_s;
              ptr_r   <= next_ptr(pick_idx_s);
              state_r <= RESP;
            end else begin
              ram_ren   <= req_ren[pick_idx_s];
              ram_wen   <= req_wen[pick_idx_s];
              ram_addr  <= req_addr[pick_idx_s];
              ram_store <= req_wdata[pick_idx_s];
              ram_strb  <= req_strb[pick_idx_s];
              cnt_r     <= '0;
              state_r   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if ((ram_state == ACCESS) || (ram_state == ERROR) || (cnt_r == CNT_MAX)) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            ptr_r   <= next_ptr(gidx_r);
            state_r <= RESP;
            if (ram_state == ACCESS) begin
              req_ready <= grant_r;
              req_rdata <= ram_load;
            end else begin
              req_err <= grant_r;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RESP: begin
          req_ready <= '0;
          req_err   <= '0;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with a small RAM model and a scoreboard
// of expected completions popped whenever a ready or err pulse appears.
module tb_mem_arbiter_rr;
  import rv32ima_pkg::*;

  localparam int NCH = 3, AW = 32, DW = 32, TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]           req_ren, req_wen, req_ready, req_err;
  logic [NCH-1:0][AW-1:0]   req_addr;
  logic [NCH-1:0][DW-1:0]   req_wdata;
  logic [NCH-1:0][DW/8-1:0] req_strb;
  logic [DW-1:0]            req_rdata, ram_store, ram_load;
  logic                     ram_ren, ram_wen;
  logic [AW-1:0]            ram_addr;
  logic [DW/8-1:0]          ram_strb;
  ram_state_t               ram_state;

  int ram_mode = 0;
  int busy_n = 0;
  int busy_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;
  int ren_cycles;

  typedef struct {
    int         ch;
    bit         is_err;
    bit         is_read;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [NCH-1:0] mon_oh;

  mem_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .req_ready(req_ready), .req_err(req_err), .req_rdata(req_rdata),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_strb(ram_strb),
    .ram_load(ram_load), .ram_state(ram_state)
  );

  always #5 clk = ~clk;

  // RAM model: mode 0 zero-wait, mode 1 BUSY for busy_n cycles, mode 2 never ready.
  always_comb begin
    ram_load = (ram_addr == 32'h100) ? 32'hDEADBEEF : {ram_addr[15:0], 16'hC0DE};
    if (!(ram_ren || ram_wen)) ram_state = FREE;
    else if (ram_mode == 0) ram_state = ACCESS;
    else if (ram_mode == 1) ram_state = (busy_cnt < busy_n) ? BUSY : ACCESS;
    else ram_state = BUSY;
  end

  always @(posedge clk) busy_cnt <= (ram_ren || ram_wen) ? busy_cnt + 1 : 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor and per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_err_excl", 64'(req_ready & req_err), 64'd0);
      check("ren_wen_excl", 64'(ram_ren & ram_wen), 64'd0);
      if ((|req_ready) || (|req_err)) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 64'({req_ready, req_err}), 64'd0);
        end else begin
          mon_e  = sb.pop_front();
          mon_oh = NCH'(1) << mon_e.ch;
          check("sb_ready", 64'(req_ready), mon_e.is_err ? 64'd0 : 64'(mon_oh));
          check("sb_err", 64'(req_err), mon_e.is_err ? 64'(mon_oh) : 64'd0);
          if (!mon_e.is_err && mon_e.is_read) check("sb_rdata", 64'(req_rdata), 64'(mon_e.rdata));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_ren"}, 64'(ram_ren), 64'd0);
    check({tag, "_ram_wen"}, 64'(ram_wen), 64'd0);
    check({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
    check({tag, "_ram_strb"}, 64'(ram_strb), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_req_err"}, 64'(req_err), 64'd0);
    check({tag, "_req_rdata"}, 64'(req_rdata), 64'd0);
  endtask

  initial begin
    rst = 1'b1; req_ren = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // Single zero-wait read from ch0.
    req_ren[0] = 1'b1; req_addr[0] = 32'h100;
    sb.push_back('{0, 1'b0, 1'b1, 32'hDEADBEEF});
    tick(1);
    check("rd_ram_ren", 64'(ram_ren), 64'd1);
    check("rd_ram_addr", 64'(ram_addr), 64'h100);
    check("rd_ready_early", 64'(req_ready), 64'd0);
    tick(1);
    check("rd_ready", 64'(req_ready), 64'b001);
    check("rd_rdata", 64'(req_rdata), 64'hDEADBEEF);
    req_ren = '0;
    tick(1);

    // ch0 and ch2 compete; pointer sits at 1 so ch2 wins first.
    req_ren[0] = 1'b1; req_addr[0] = 32'h200;
    req_ren[2] = 1'b1; req_addr[2] = 32'h300;
    sb.push_back('{2, 1'b0, 1'b1, 32'h0300C0DE});
    sb.push_back('{0, 1'b0, 1'b1, 32'h0200C0DE});
    sb.push_back('{2, 1'b0, 1'b1, 32'h0300C0DE});
    sb.push_back('{0, 1'b0, 1'b1, 32'h0200C0DE});
    tick(2); check("rr_g0", 64'(req_ready), 64'b100);
    tick(3); check("rr_g1", 64'(req_ready), 64'b001);
    tick(3); check("rr_g2", 64'(req_ready), 64'b100);
    tick(3); check("rr_g3", 64'(req_ready), 64'b001);
    req_ren = '0;
    tick(1);

    // ch1 write against a RAM that stays BUSY for three cycles.
    ram_mode = 1; busy_n = 3;
    req_wen[1] = 1'b1; req_addr[1] = 32'h400; req_wdata[1] = 32'h12345678; req_strb[1] = 4'b0011;
    sb.push_back('{1, 1'b0, 1'b0, 32'h0});
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("wr_ram_wen", 64'(ram_wen), 64'd1);
      check("wr_ram_addr", 64'(ram_addr), 64'h400);
      check("wr_ram_strb", 64'(ram_strb), 64'b0011);
      check("wr_ram_store", 64'(ram_store), 64'h12345678);
    end
    tick(1);
    check("wr_ready", 64'(req_ready), 64'b010);
    check("wr_wen_off", 64'(ram_wen), 64'd0);
    req_wen = '0;
    tick(1);

    // RAM never reaches ACCESS: timeout after exactly TIMEOUT strobe cycles.
    ram_mode = 2;
    req_ren[2] = 1'b1; req_addr[2] = 32'h500;
    sb.push_back('{2, 1'b1, 1'b1, 32'h0});
    ren_cycles = 0;
    for (int k = 0; k < 40 && req_err == '0; k++) begin
      tick(1);
      if (ram_ren) ren_cycles++;
    end
    check("to_ren_cycles", 64'(ren_cycles), 64'd16);
    check("to_err", 64'(req_err), 64'b100);
    req_ren = '0;
    tick(1);
    check("to_idle_ren", 64'(ram_ren), 64'd0);

    // ren and wen together on ch0: immediate error, no RAM strobe.
    ram_mode = 0;
    req_ren[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 32'h123;
    sb.push_back('{0, 1'b1, 1'b0, 32'h0});
    tick(1);
    check("cf_err", 64'(req_err), 64'b001);
    check("cf_ram_ren", 64'(ram_ren), 64'd0);
    check("cf_ram_wen", 64'(ram_wen), 64'd0);
    req_ren = '0; req_wen = '0;
    tick(1);

    // Reset during ISSUE abandons the request silently.
    ram_mode = 2;
    req_ren[1] = 1'b1; req_addr[1] = 32'h600;
    tick(1);
    check("mr_ram_ren", 64'(ram_ren), 64'd1);
    tick(2);
    rst = 1'b1; req_ren = '0;
    tick(1);
    check_all_zero("midreset");
    rst = 1'b0; ram_mode = 0;
    tick(1);

    // After reset the pointer restarts at 0: ch1 before ch2.
    req_ren[1] = 1'b1; req_addr[1] = 32'h700;
    req_ren[2] = 1'b1; req_addr[2] = 32'h800;
    sb.push_back('{1, 1'b0, 1'b1, 32'h0700C0DE});
    sb.push_back('{2, 1'b0, 1'b1, 32'h0800C0DE});
    tick(1);
    check("pr_ram_addr", 64'(ram_addr), 64'h700);
    tick(1); check("pr_g0", 64'(req_ready), 64'b010);
    tick(3); check("pr_g1", 64'(req_ready), 64'b100);
    req_ren = '0;
    tick(3);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
